dmem_arbiter: RTL and testbench

- Arbitrates the single data_mem port between two requesters.
- Port 0 is the pipeline MEM stage, serving LDW and STR.
- Port 1 is the debug/loader master, which preloads and inspects data memory.
- Sits between mem_stage, the debug block and data_mem, driving data_mem's write-data, address, read-source and write-enable inputs.
- Pipeline traffic has priority. A starvation counter and a bounded burst lock guarantee port 1 progress without stalling the pipeline indefinitely.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_rd_capture.sv | 37 +++
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, FSM state
// encodings and the bundled request record used by the memory-side mux.
package dmem_arbiter_pkg;

  // Data and address widths of the data_mem port.
  localparam int AW = 4;
  localparam int DW = 32;

  // Requester indices: pipeline MEM stage and debug/loader master.
  localparam logic [0:0] P_MEM = 1'b0;
  localparam logic [0:0] P_DBG = 1'b1;

  // Arbiter FSM encodings.
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_BURST1 = 1'b1;

  // One requester's transaction fields, as presented to data_mem.
  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_rd_capture.sv
// Read-return stage: captures the combinational data_mem read value into a
// per-port holding register on the accept edge of a read, and raises that
// port's rvalid for exactly the following cycle.
module dmem_rd_capture
  import dmem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    rd_fire,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);

  logic [1:0]    rvalid_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  // Capture read data on accepted reads; rdata holds until the next read on that port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire[P_MEM]) rdata0_q <= mem_rdata;
      if (rd_fire[P_DBG]) rdata1_q <= mem_rdata;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of data_mem. Port 0 (pipeline MEM stage) has
// priority; port 1 (debug/loader) is protected from starvation by a wait
// counter that forces a grant after MAX_WAIT denied cycles, and may hold the
// port for a bounded burst while p1_lock is asserted.
//
// Handshake: each port is valid/ready. A requester raises pX_req with its
// fields and holds them stable until it sees pX_gnt; the transfer happens on
// the rising edge where pX_req=1 and pX_gnt=1. pX_gnt is combinational from
// pX_req and registered arbiter state, and at most one port is granted.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  // port 0: pipeline MEM stage
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  // port 1: debug / loader master
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_lock,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  // data_mem side
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  // observability of arbiter state
  output logic [0:0]    dbg_state,
  output logic [CW-1:0] dbg_wait_cnt,
  output logic [CW-1:0] dbg_burst_cnt
);

  localparam logic [CW-1:0] MAX_WAIT_C     = CW'(MAX_WAIT);
  // burst_cnt counts completed port-1 beats/cycles of the lock; the one that
  // brings the count up to MAX_BURST is the last the lock may take.
  localparam logic [CW-1:0] BURST_LAST_C   = CW'(MAX_BURST - 1);

  logic [0:0]    state_q,     state_d;
  logic [CW-1:0] wait_cnt_q,  wait_cnt_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  // Set for the single ARB cycle following a burst: p0 keeps its priority.
  logic          prio_q,      prio_d;

  logic          force_p1;
  logic          gnt0;
  logic          gnt1;
  mem_req_t      p0_bus;
  mem_req_t      p1_bus;
  mem_req_t      mem_sel;
  logic [1:0]    rd_fire;

  assign p0_bus = '{req: p0_req, we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign p1_bus = '{req: p1_req, we: p1_we, addr: p1_addr, wdata: p1_wdata};

  // Starvation override: p1 has waited MAX_WAIT cycles and is not in the
  // post-burst p0 priority cycle.
  assign force_p1 = (state_q == ST_ARB) && p1_req &&
                    (wait_cnt_q == MAX_WAIT_C) && !prio_q;

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (state_q == ST_ARB) begin
        if (force_p1)    gnt1 = 1'b1;
        else if (p0_req) gnt0 = 1'b1;
        else if (p1_req) gnt1 = 1'b1;
      end else begin
        gnt1 = p1_req;
      end
    end
  end

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  // Next-state logic for the FSM, wait counter and burst counter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    prio_d      = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (gnt1 || !p1_req) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (gnt1 && p1_lock) begin
          state_d     = ST_BURST1;
          burst_cnt_d = CW'(1);
        end
      end
      ST_BURST1: begin
        // Idle locked cycles count against the limit too, so p0 can never
        // be shut out longer than MAX_BURST cycles.
        wait_cnt_d  = '0;
        burst_cnt_d = burst_cnt_q + 1'b1;
        if (!p1_lock || (burst_cnt_q == BURST_LAST_C)) begin
          state_d     = ST_ARB;
          burst_cnt_d = '0;
          prio_d      = 1'b1;
        end
      end
      default: begin
        state_d     = ST_ARB;
        wait_cnt_d  = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Arbiter state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ARB;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      prio_q      <= prio_d;
    end
  end

  // Memory-side mux: route the granted port, all zero when idle.
  always_comb begin
    mem_sel = '0;
    if (gnt0)      mem_sel = p0_bus;
    else if (gnt1) mem_sel = p1_bus;
  end

  assign mem_we    = mem_sel.req & mem_sel.we;
  assign mem_waddr = mem_sel.addr;
  assign mem_raddr = mem_sel.addr;
  assign mem_wdata = mem_sel.wdata;

  // Accepted reads per port, indexed by requester.
  always_comb begin
    rd_fire        = '0;
    rd_fire[P_MEM] = gnt0 & ~p0_we;
    rd_fire[P_DBG] = gnt1 & ~p1_we;
  end

  dmem_rd_capture u_rd_capture (
    .clk       (clk),
    .rst       (rst),
    .rd_fire   (rd_fire),
    .mem_rdata (mem_rdata),
    .rvalid    ({p1_rvalid, p0_rvalid}),
    .rdata0    (p0_rdata),
    .rdata1    (p1_rdata)
  );

  assign dbg_state     = state_q;
  assign dbg_wait_cnt  = wait_cnt_q;
  assign dbg_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small behavioural data_mem, a
// table of single-cycle vectors, and hand-written multi-cycle sequences for
// the starvation override, burst limit and reset-during-burst cases.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [3:0]  p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [3:0]  p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_waddr, mem_raddr;
  logic        mem_we;
  logic [0:0]  dbg_state;
  logic [3:0]  dbg_wait_cnt, dbg_burst_cnt;

  dmem_arbiter #(.MAX_WAIT(4), .MAX_BURST(8), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt), .dbg_burst_cnt(dbg_burst_cnt)
  );

  // ---------------- data_mem model ----------------
  // Word i starts as 0xA000_0000 | i.
  logic [31:0] tb_mem [16];
  logic        mem_load;
  assign mem_rdata = tb_mem[mem_raddr];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (mem_we) begin
      tb_mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r0, input logic w0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [3:0] a1, input logic [31:0] d1,
                       input logic lk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = lk;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        p0_req, p0_we;  logic [3:0] p0_addr; logic [31:0] p0_wdata;
    logic        p1_req, p1_we;  logic [3:0] p1_addr; logic [31:0] p1_wdata; logic p1_lock;
    logic        e_g0, e_g1, e_we, e_rv0; logic [31:0] e_rd0;
    logic        e_rv1;          logic [31:0] e_rd1;  logic [3:0] e_wait;
  } vec_t;

  vec_t vecs [12];

  // Watchdog: the flow is fixed-length, this only guards against a stuck sim.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  b;
    logic eg0, eg1;
    logic [0:0] est;

    // Rows: inputs for the cycle, then outputs seen before its edge.
    // rvalid/rdata reflect the read accepted one row earlier.
    vecs[0]  = '{1'b0,1'b0,4'd0,32'h0,  1'b0,1'b0,4'd0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,4'd0};
    vecs[1]  = '{1'b1,1'b1,4'd3,32'hAA, 1'b0,1'b0,4'd0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,4'd0};
    vecs[2]  = '{1'b1,1'b0,4'd3,32'h0,  1'b0,1'b0,4'd0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,4'd0};
    vecs[3]  = '{1'b0,1'b0,4'd0,32'h0,  1'b0,1'b0,4'd0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b1,32'hAA, 1'b0,32'h0,4'd0};
    vecs[4]  = '{1'b0,1'b0,4'd0,32'h0,  1'b0,1'b0,4'd0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'hAA, 1'b0,32'h0,4'd0};
    vecs[5]  = '{1'b1,1'b1,4'd7,32'h11, 1'b0,1'b0,4'd0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b0,32'hAA, 1'b0,32'h0,4'd0};
    vecs[6]  = '{1'b1,1'b0,4'd7,32'h0,  1'b1,1'b1,4'd7,32'h77,1'b0,1'b1,1'b0,1'b0,1'b0,32'hAA, 1'b0,32'h0,4'd0};
    vecs[7]  = '{1'b0,1'b0,4'd0,32'h0,  1'b1,1'b1,4'd7,32'h77,1'b0,1'b0,1'b1,1'b1,1'b1,32'h11, 1'b0,32'h0,4'd1};
    vecs[8]  = '{1'b1,1'b0,4'd7,32'h0,  1'b0,1'b0,4'd0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h11, 1'b0,32'h0,4'd0};
    vecs[9]  = '{1'b0,1'b0,4'd0,32'h0,  1'b0,1'b0,4'd0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b1,32'h77, 1'b0,32'h0,4'd0};
    vecs[10] = '{1'b0,1'b0,4'd0,32'h0,  1'b1,1'b0,4'd2,32'h0,1'b0, 1'b0,1'b1,1'b0,1'b0,32'h77, 1'b0,32'h0,4'd0};
    vecs[11] = '{1'b0,1'b0,4'd0,32'h0,  1'b0,1'b0,4'd0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h77, 1'b1,32'hA000_0002,4'd0};

    // ---- reset: requests present while rst=0 must not be granted ----
    rst = 1'b0; mem_load = 1'b1;
    drive(1'b1, 1'b1, 4'd1, 32'hFF, 1'b1, 1'b1, 4'd2, 32'hEE, 1'b0);
    @(negedge clk); #1;
    chk_bit("rst p0_gnt", p0_gnt, 1'b0);
    chk_bit("rst p1_gnt", p1_gnt, 1'b0);
    chk_bit("rst mem_we", mem_we, 1'b0);
    @(negedge clk); mem_load = 1'b0; idle();
    @(negedge clk); rst = 1'b1;

    // ---- table-driven single-cycle vectors ----
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].p0_req, vecs[i].p0_we, vecs[i].p0_addr, vecs[i].p0_wdata,
            vecs[i].p1_req, vecs[i].p1_we, vecs[i].p1_addr, vecs[i].p1_wdata, vecs[i].p1_lock);
      #1;
      chk_bit ($sformatf("row%0d p0_gnt", i),    p0_gnt,    vecs[i].e_g0);
      chk_bit ($sformatf("row%0d p1_gnt", i),    p1_gnt,    vecs[i].e_g1);
      chk_bit ($sformatf("row%0d mem_we", i),    mem_we,    vecs[i].e_we);
      chk_bit ($sformatf("row%0d p0_rvalid", i), p0_rvalid, vecs[i].e_rv0);
      chk_word($sformatf("row%0d p0_rdata", i),  p0_rdata,  vecs[i].e_rd0);
      chk_bit ($sformatf("row%0d p1_rvalid", i), p1_rvalid, vecs[i].e_rv1);
      chk_word($sformatf("row%0d p1_rdata", i),  p1_rdata,  vecs[i].e_rd1);
      chk_word($sformatf("row%0d wait_cnt", i),  32'(dbg_wait_cnt), 32'(vecs[i].e_wait));
    end

    // ---- starvation: p0 streams reads, p1 read of addr 5 forced on 5th cycle ----
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd5, 32'h0, 1'b0);
      #1;
      chk_bit ($sformatf("starve c%0d p0_gnt", c), p0_gnt, (c != 4));
      chk_bit ($sformatf("starve c%0d p1_gnt", c), p1_gnt, (c == 4));
      chk_word($sformatf("starve c%0d wait_cnt", c), 32'(dbg_wait_cnt), 32'(c));
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    #1;
    chk_bit ("starve p1_rvalid", p1_rvalid, 1'b1);
    chk_word("starve p1_rdata",  p1_rdata,  32'hA000_0005);
    chk_bit ("starve p0_regrant", p0_gnt,   1'b1);
    @(negedge clk); idle();

    // ---- burst: 10 locked p1 writes to addr 0..9 while p0 wants the port ----
    // Expected: p0 cycles 0-3, p1 beats cycles 4-11 (8), p0 cycle 12,
    // p1 resumes cycles 13-14 once p0 has dropped its request.
    b = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (b < 10) drive((c <= 12), 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 4'(b), 32'hB0 + 32'(b), 1'b1);
      else        drive((c <= 12), 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      #1;
      eg0 = (c <= 3) || (c == 12);
      eg1 = ((c >= 4) && (c <= 11)) || (c == 13) || (c == 14);
      est = (((c >= 5) && (c <= 11)) || (c == 14) || (c == 15)) ? ST_BURST1 : ST_ARB;
      chk_bit($sformatf("burst c%0d p0_gnt", c), p0_gnt, eg0);
      chk_bit($sformatf("burst c%0d p1_gnt", c), p1_gnt, eg1);
      chk_bit($sformatf("burst c%0d state", c),  dbg_state[0], est[0]);
      if (p1_req && p1_gnt) b++;
    end
    for (int i = 0; i < 10; i++) exp_q.push_back(32'hB0 + 32'(i));
    for (int i = 0; i < 10; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      chk_word($sformatf("burst mem[%0d]", i), tb_mem[i], e);
    end

    // ---- reset asserted during a BURST1 write ----
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 4'd12, 32'hC0, 1'b1);
    #1;
    chk_bit("rstb beat0 p1_gnt", p1_gnt, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 4'd3, 32'h0, 1'b1, 1'b1, 4'd13, 32'hDD, 1'b1);
    #1;
    chk_bit("rstb state burst", dbg_state[0], ST_BURST1[0]);
    chk_bit("rstb p1_gnt",      p1_gnt,       1'b0);
    chk_bit("rstb mem_we",      mem_we,       1'b0);
    @(negedge clk);
    rst = 1'b1; idle();
    #1;
    chk_bit ("rstb state arb",  dbg_state[0], ST_ARB[0]);
    chk_bit ("rstb p0_rvalid",  p0_rvalid,    1'b0);
    chk_bit ("rstb p1_rvalid",  p1_rvalid,    1'b0);
    chk_word("rstb p0_rdata",   p0_rdata,     32'h0);
    chk_word("rstb p1_rdata",   p1_rdata,     32'h0);
    chk_word("rstb wait_cnt",   32'(dbg_wait_cnt),  32'h0);
    chk_word("rstb burst_cnt",  32'(dbg_burst_cnt), 32'h0);
    chk_word("rstb mem[12]",    tb_mem[12],   32'hC0);
    chk_word("rstb mem[13]",    tb_mem[13],   32'hA000_000D);

    // ---- idle: no grants, no writes, wait_cnt stays 0 ----
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); #1;
      chk_bit ($sformatf("idle c%0d p0_gnt", c), p0_gnt, 1'b0);
      chk_bit ($sformatf("idle c%0d p1_gnt", c), p1_gnt, 1'b0);
      chk_bit ($sformatf("idle c%0d mem_we", c), mem_we, 1'b0);
      chk_word($sformatf("idle c%0d wait_cnt", c), 32'(dbg_wait_cnt), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
